dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter. Requester A (CPU) and B (debug/DMA)
// share one data memory through a fixed three-cycle access:
// IDLE (accept) -> ACCESS (memory cycle) -> RESP (one-cycle response strobe).
// Ties are resolved round-robin. Illegal, misaligned and out-of-range
// accesses are rejected at acceptance and never write memory.
module dmem_arbiter #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_0400
) (
  input  logic        cpu_clk,
  input  logic        rst,
  // requester A (CPU)
  input  logic        a_valid,
  output logic        a_ready,
  input  logic        a_we,
  input  logic [1:0]  a_func3,
  input  logic [31:0] a_adr,
  input  logic [31:0] a_wdata,
  output logic        a_rsp_valid,
  output logic [31:0] a_rdata,
  output logic        a_err,
  // requester B (debug/DMA)
  input  logic        b_valid,
  output logic        b_ready,
  input  logic        b_we,
  input  logic [1:0]  b_func3,
  input  logic [31:0] b_adr,
  input  logic [31:0] b_wdata,
  output logic        b_rsp_valid,
  output logic [31:0] b_rdata,
  output logic        b_err,
  // data memory
  output logic [31:0] mem_adr,
  output logic [31:0] mem_dataW,
  output logic        mem_MEMRW,
  output logic [1:0]  mem_func3,
  input  logic [31:0] mem_dataR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  state_t      state, state_nxt;
  req_id_t     last_grant;

  // Latched request, captured only on acceptance.
  req_id_t     req_id;
  logic        req_we;
  logic [1:0]  req_func3;
  logic [31:0] req_adr;
  logic [31:0] req_wdata;
  logic        req_err;

  // Response data captured at the end of ACCESS.
  logic [31:0] rsp_data;

  logic        grant_a, grant_b, accept;
  logic        sel_we;
  logic [1:0]  sel_func3;
  logic [31:0] sel_adr, sel_wdata;
  logic        sel_err;

  // Size/alignment/range legality of a request.
  function automatic logic access_err(input logic [1:0] func3, input logic [31:0] adr);
    logic bad_size;
    case (func3)
      2'b00:   bad_size = 1'b0;
      2'b01:   bad_size = adr[0];
      2'b10:   bad_size = |adr[1:0];
      default: bad_size = 1'b1;
    endcase
    return bad_size || (adr >= ADDR_LIMIT);
  endfunction

  // Round-robin winner selection; only granted while IDLE and out of reset.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the block leaves a value held and no latch is inferred.
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state == IDLE && !rst) begin
      if (a_valid && b_valid) begin
        grant_a = (last_grant == REQ_B);
        grant_b = (last_grant == REQ_A);
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  assign accept    = grant_a | grant_b;
  assign sel_we    = grant_b ? b_we    : a_we;
  assign sel_func3 = grant_b ? b_func3 : a_func3;
  assign sel_adr   = grant_b ? b_adr   : a_adr;
  assign sel_wdata = grant_b ? b_wdata : a_wdata;
  assign sel_err   = access_err(sel_func3, sel_adr);

  // State register and last-grant pointer.
  always_ff @(posedge cpu_clk) begin
    // NOTE: state elements use non-blocking assignments so every flop sees
    // the pre-edge values of the others, regardless of statement order.
    if (rst) begin
      state      <= IDLE;
      last_grant <= REQ_B;
    end else begin
      state <= state_nxt;
      if (accept) last_grant <= grant_b ? REQ_B : REQ_A;
    end
  end

  // Capture the winning request; later input changes are ignored.
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      req_id    <= REQ_A;
      req_we    <= 1'b0;
      req_func3 <= 2'b00;
      req_adr   <= 32'd0;
      req_wdata <= 32'd0;
      req_err   <= 1'b0;
    end else if (accept) begin
      req_id    <= grant_b ? REQ_B : REQ_A;
      req_we    <= sel_we;
      req_func3 <= sel_func3;
      req_adr   <= sel_adr;
      req_wdata <= sel_wdata;
      req_err   <= sel_err;
    end
  end

  // Register load data at the end of ACCESS; stores and errors return zero.
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      rsp_data <= 32'd0;
    end else if (state == ACCESS) begin
      rsp_data <= (!req_we && !req_err) ? mem_dataR : 32'd0;
    end
  end

  // Next state plus memory-side and response-side outputs.
  always_comb begin
    state_nxt   = state;
    a_ready     = grant_a;
    b_ready     = grant_b;
    a_rsp_valid = 1'b0;
    a_rdata     = 32'd0;
    a_err       = 1'b0;
    b_rsp_valid = 1'b0;
    b_rdata     = 32'd0;
    b_err       = 1'b0;
    mem_adr     = 32'd0;
    mem_dataW   = 32'd0;
    mem_MEMRW   = 1'b0;
    mem_func3   = 2'b00;

    case (state)
      IDLE:    if (accept) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Reset forces every output low, so a reset during ACCESS never writes.
    if (!rst) begin
      if (state == ACCESS) begin
        mem_adr   = req_adr;
        mem_dataW = req_wdata;
        mem_func3 = req_func3;
        mem_MEMRW = req_we && !req_err;
      end
      if (state == RESP) begin
        if (req_id == REQ_A) begin
          a_rsp_valid = 1'b1;
          a_rdata     = rsp_data;
          a_err       = req_err;
        end else begin
          b_rsp_valid = 1'b1;
          b_rdata     = rsp_data;
          b_err       = req_err;
        end
      end
    end
  end

endmodule
